dma_bus_arbiter: RTL and testbench

//  Single-bus arbiter between the processor and the DMA controller in front of the shared 1K x 8 memory.

---
 rtl/dma_bus_arbiter_pkg.sv | 41 ++++
 rtl/dma_bus_arbiter_if.sv | 39 +++
 rtl/dma_bus_arbiter_tenure_cnt.sv | 32 +++
 rtl/dma_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared constants and types for the CPU/DMA single-bus arbiter.
// Holds the bus width defaults, the owner and state encodings, the active-low
// grant/request levels and the read/write levels of the rw_ lines.
package dma_bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    // Active-low request/grant levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // rw_ line levels
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CPU  = 2'b01,
        ST_DMA  = 2'b10,
        ST_TURN = 2'b11
    } state_e;

    // Bus owner implied by an arbiter state; TURN and IDLE own nothing.
    function automatic owner_e owner_of(input state_e st);
        owner_e own;
        case (st)
            ST_CPU:  own = OWN_CPU;
            ST_DMA:  own = OWN_DMA;
            default: own = OWN_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the memory port.
// slave: the arbiter's view. master: the requesters'/memory side view.
interface dma_bus_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              cpu_breq_;
    logic              cpu_bgrt_;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rw_;

    logic              dma_breq_;
    logic              dma_bgrt_;
    logic              dma_eop_;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_rw_;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [1:0]        owner;

    modport slave (
        input  cpu_breq_, cpu_addr, cpu_wdata, cpu_rw_,
        input  dma_breq_, dma_eop_, dma_addr, dma_wdata, dma_rw_,
        output cpu_bgrt_, dma_bgrt_,
        output mem_addr, mem_wdata, mem_we, owner
    );

    modport master (
        output cpu_breq_, cpu_addr, cpu_wdata, cpu_rw_,
        output dma_breq_, dma_eop_, dma_addr, dma_wdata, dma_rw_,
        input  cpu_bgrt_, dma_bgrt_,
        input  mem_addr, mem_wdata, mem_we, owner
    );

endinterface

// File: rtl/dma_bus_arbiter_tenure_cnt.sv
// DMA tenure counter: counts granted DMA cycles, saturating at MAX_TEN-1.
// clr has priority over inc; at_limit flags that the tenure budget is used up.
module arb_tenure_cnt #(
    parameter int MAX_TEN = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam logic [7:0] LIMIT = 8'(MAX_TEN - 1);

    logic [7:0] cnt_r;

    // Saturating tenure count, cleared whenever the DMA tenure ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (inc && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_limit = (cnt_r == LIMIT);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Single-bus arbiter between the CPU and the DMA controller in front of the
// shared memory. DMA has fixed priority but a bounded tenure while the CPU
// waits; every change of owner passes through one idle TURN cycle.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_TEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    dma_bus_arbiter_if.slave  bus
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              pre_r;        // last DMA tenure ended by preemption
    logic              pre_nxt_s;
    logic              cpu_bgrt_r;
    logic              dma_bgrt_r;
    owner_e            owner_r;
    logic              cnt_clr_s;
    logic              cnt_inc_s;
    logic              at_limit_s;
    logic              dma_last_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              mem_we_s;

    arb_tenure_cnt #(
        .MAX_TEN (MAX_TEN)
    ) u_tenure_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr_s),
        .inc      (cnt_inc_s),
        .at_limit (at_limit_s)
    );

    // DMA gives up the bus on its own: request dropped or end-of-process
    assign dma_last_s = (bus.dma_breq_ == DISABLE_) || (bus.dma_eop_ == ENABLE_);

    // Next-state, preemption memory and tenure counter control
    always_comb begin
        state_nxt_s = state_r;
        pre_nxt_s   = pre_r;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.dma_breq_ == ENABLE_) begin
                    state_nxt_s = ST_DMA;
                end else if (bus.cpu_breq_ == ENABLE_) begin
                    state_nxt_s = ST_CPU;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CPU: begin
                if (bus.cpu_breq_ == DISABLE_) begin
                    state_nxt_s = ST_TURN;
                end else begin
                    state_nxt_s = ST_CPU;
                end
            end
            ST_DMA: begin
                cnt_inc_s = 1'b1;
                if (dma_last_s) begin
                    state_nxt_s = ST_TURN;
                    cnt_clr_s   = 1'b1;
                    pre_nxt_s   = 1'b0;
                end else if ((bus.cpu_breq_ == ENABLE_) && at_limit_s) begin
                    state_nxt_s = ST_TURN;
                    cnt_clr_s   = 1'b1;
                    pre_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_DMA;
                end
            end
            ST_TURN: begin
                // A preempted CPU gets one tenure before DMA may return
                pre_nxt_s = 1'b0;
                if (pre_r && (bus.cpu_breq_ == ENABLE_)) begin
                    state_nxt_s = ST_CPU;
                end else if (bus.dma_breq_ == ENABLE_) begin
                    state_nxt_s = ST_DMA;
                end else if (bus.cpu_breq_ == ENABLE_) begin
                    state_nxt_s = ST_CPU;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pre_nxt_s   = 1'b0;
                cnt_clr_s   = 1'b1;
            end
        endcase
    end

    // State register with grants and owner registered alongside it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pre_r      <= 1'b0;
            cpu_bgrt_r <= DISABLE_;
            dma_bgrt_r <= DISABLE_;
            owner_r    <= OWN_NONE;
        end else begin
            state_r    <= state_nxt_s;
            pre_r      <= pre_nxt_s;
            cpu_bgrt_r <= (state_nxt_s == ST_CPU) ? ENABLE_ : DISABLE_;
            dma_bgrt_r <= (state_nxt_s == ST_DMA) ? ENABLE_ : DISABLE_;
            owner_r    <= owner_of(state_nxt_s);
        end
    end

    // Memory port mux: follows the registered owner, quiet when nobody owns
    always_comb begin
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        mem_we_s    = 1'b0;
        case (owner_r)
            OWN_CPU: begin
                mem_addr_s  = bus.cpu_addr;
                mem_wdata_s = bus.cpu_wdata;
                mem_we_s    = (bus.cpu_rw_ == WRITE);
            end
            OWN_DMA: begin
                mem_addr_s  = bus.dma_addr;
                mem_wdata_s = bus.dma_wdata;
                mem_we_s    = (bus.dma_rw_ == WRITE);
            end
            default: begin
                mem_addr_s  = '0;
                mem_wdata_s = '0;
                mem_we_s    = 1'b0;
            end
        endcase
    end

    assign bus.cpu_bgrt_ = cpu_bgrt_r;
    assign bus.dma_bgrt_ = dma_bgrt_r;
    assign bus.owner     = owner_r;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.mem_we    = mem_we_s;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: a cycle model pushes the expected
// output word each cycle, popped and compared after the clock edge, plus
// directed checks of tenure lengths and reset behaviour.
module tb_dma_bus_arbiter;

    localparam int MAX_TEN = 16;
    localparam int S_IDLE = 0;
    localparam int S_CPU  = 1;
    localparam int S_DMA  = 2;
    localparam int S_TURN = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dma_bus_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus();

    dma_bus_arbiter #(
        .ADDR_W  (10),
        .DATA_W  (8),
        .MAX_TEN (MAX_TEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          m_state  = S_IDLE;
    int          m_cnt    = 0;
    bit          m_pre    = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_out();
        return {9'd0, bus.cpu_bgrt_, bus.dma_bgrt_, bus.owner, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    endfunction

    // Expected output word for the model state and the inputs now applied
    function automatic logic [31:0] model_out();
        logic       cb, db, we;
        logic [1:0] own;
        logic [9:0] a;
        logic [7:0] w;
        cb = 1'b1; db = 1'b1; own = 2'd0; we = 1'b0; a = 10'd0; w = 8'd0;
        if (m_state == S_CPU) begin
            cb = 1'b0; own = 2'd1; a = bus.cpu_addr; w = bus.cpu_wdata; we = ~bus.cpu_rw_;
        end else if (m_state == S_DMA) begin
            db = 1'b0; own = 2'd2; a = bus.dma_addr; w = bus.dma_wdata; we = ~bus.dma_rw_;
        end
        return {9'd0, cb, db, own, we, a, w};
    endfunction

    // Advance the reference model by one clock edge using the current inputs
    task automatic model_edge();
        bit cpu_req, dma_req, dma_done, preempt;
        cpu_req  = (bus.cpu_breq_ == 1'b0);
        dma_req  = (bus.dma_breq_ == 1'b0);
        dma_done = !dma_req || (bus.dma_eop_ == 1'b0);
        if (m_state == S_IDLE || m_state == S_TURN) begin
            if (m_state == S_TURN && m_pre && cpu_req) m_state = S_CPU;
            else if (dma_req)                          m_state = S_DMA;
            else if (cpu_req)                          m_state = S_CPU;
            else                                       m_state = S_IDLE;
            m_pre = 1'b0;
        end else if (m_state == S_CPU) begin
            if (!cpu_req) m_state = S_TURN;
        end else begin
            preempt = !dma_done && cpu_req && (m_cnt == MAX_TEN - 1);
            if (dma_done || preempt) begin
                m_state = S_TURN;
                m_cnt   = 0;
                m_pre   = preempt;
            end else if (m_cnt < MAX_TEN - 1) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_cnt   = 0;
        m_pre   = 1'b0;
    endtask

    // One clock: push the expectation, let the edge happen, pop and compare
    task automatic step(input string tag);
        model_edge();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        check_val(tag, dut_out(), exp_q.pop_front());
    endtask

    task automatic idle_inputs();
        bus.cpu_breq_ = 1'b1; bus.cpu_addr = 10'd0; bus.cpu_wdata = 8'd0; bus.cpu_rw_ = 1'b1;
        bus.dma_breq_ = 1'b1; bus.dma_eop_ = 1'b1; bus.dma_addr = 10'd0;
        bus.dma_wdata = 8'd0; bus.dma_rw_ = 1'b1;
    endtask

    initial begin
        int granted;
        logic [1:0] prev_own;
        logic bad;

        // Reset at t0
        reset = 1'b1;
        idle_inputs();
        #7;
        check_val("rst_cpu_bgrt", {31'd0, bus.cpu_bgrt_}, 32'd1);
        check_val("rst_dma_bgrt", {31'd0, bus.dma_bgrt_}, 32'd1);
        check_val("rst_owner",    {30'd0, bus.owner},     32'd0);
        check_val("rst_mem_we",   {31'd0, bus.mem_we},    32'd0);
        check_val("rst_mem_addr", {22'd0, bus.mem_addr},  32'd0);
        #5;
        reset = 1'b0;
        model_reset();
        step("idle0");
        step("idle1");

        // CPU write from IDLE
        bus.cpu_breq_ = 1'b0; bus.cpu_addr = 10'h150; bus.cpu_wdata = 8'h99; bus.cpu_rw_ = 1'b0;
        step("cpu_grant");
        check_val("cpu_bgrt_low", {31'd0, bus.cpu_bgrt_}, 32'd0);
        check_val("cpu_mem_addr", {22'd0, bus.mem_addr},  32'h150);
        check_val("cpu_mem_data", {24'd0, bus.mem_wdata}, 32'h99);
        check_val("cpu_mem_we",   {31'd0, bus.mem_we},    32'd1);
        bus.cpu_breq_ = 1'b1;
        step("cpu_turn");
        check_val("cpu_turn_own", {30'd0, bus.owner}, 32'd0);
        step("cpu_idle");

        // Simultaneous requests: DMA wins, both drop in the granted cycle
        bus.cpu_breq_ = 1'b0; bus.dma_breq_ = 1'b0; bus.dma_rw_ = 1'b1; bus.dma_addr = 10'h3a;
        step("both_req");
        check_val("both_dma_bgrt", {31'd0, bus.dma_bgrt_}, 32'd0);
        check_val("both_cpu_bgrt", {31'd0, bus.cpu_bgrt_}, 32'd1);
        bus.cpu_breq_ = 1'b1; bus.dma_breq_ = 1'b1;
        step("both_turn");
        step("both_idle");

        // DMA burst ended by eop_ on the 4th granted cycle, CPU waiting
        bus.dma_breq_ = 1'b0; bus.dma_rw_ = 1'b0; bus.dma_addr = 10'h150; bus.dma_wdata = 8'h11;
        step("burst_grant");
        granted = 0;
        for (int k = 1; k <= 4; k++) begin
            bus.dma_addr  = 10'h150 + 10'(((k - 1) * 16) / 3);
            bus.dma_wdata = 8'(8'h10 + k);
            bus.dma_eop_  = (k == 4) ? 1'b0 : 1'b1;
            if (k == 2) bus.cpu_breq_ = 1'b0;
            if (bus.dma_bgrt_ == 1'b0) granted++;
            step("burst");
        end
        check_val("burst_len",       granted, 32'd4);
        check_val("burst_turn_dma",  {31'd0, bus.dma_bgrt_}, 32'd1);
        check_val("burst_turn_cpu",  {31'd0, bus.cpu_bgrt_}, 32'd1);
        bus.dma_breq_ = 1'b1; bus.dma_eop_ = 1'b1;
        step("burst_cpu");
        check_val("burst_cpu_bgrt", {31'd0, bus.cpu_bgrt_}, 32'd0);
        bus.cpu_breq_ = 1'b1;
        step("burst_cpu_turn");
        step("burst_idle");

        // Tenure limit: DMA holds its request while the CPU waits
        bus.dma_breq_ = 1'b0; bus.cpu_breq_ = 1'b0; bus.cpu_rw_ = 1'b1;
        step("ten_grant");
        granted = (bus.dma_bgrt_ == 1'b0) ? 1 : 0;
        for (int i = 0; i < 3 * MAX_TEN; i++) begin
            step("ten");
            if (bus.dma_bgrt_ == 1'b0) granted++;
            else break;
        end
        check_val("ten_len",      granted, MAX_TEN);
        check_val("ten_turn_own", {30'd0, bus.owner}, 32'd0);
        step("ten_cpu");
        check_val("ten_cpu_bgrt", {31'd0, bus.cpu_bgrt_}, 32'd0);
        step("ten_cpu_hold0");
        step("ten_cpu_hold1");
        bus.cpu_breq_ = 1'b1;
        step("ten_cpu_turn");
        check_val("ten_turn2_bgrts", {30'd0, bus.cpu_bgrt_, bus.dma_bgrt_}, 32'd3);
        step("ten_regrant");
        check_val("ten_dma_regrant", {31'd0, bus.dma_bgrt_}, 32'd0);

        // Reset in the middle of a DMA write tenure
        bus.dma_rw_ = 1'b0; bus.dma_addr = 10'h33;
        step("rst_mid_pre");
        check_val("rst_mid_we_pre", {31'd0, bus.mem_we}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_mid_dma_bgrt", {31'd0, bus.dma_bgrt_}, 32'd1);
        check_val("rst_mid_mem_we",   {31'd0, bus.mem_we},    32'd0);
        check_val("rst_mid_owner",    {30'd0, bus.owner},     32'd0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        step("post_rst");

        // Random traffic with exclusivity and turnaround checks
        prev_own = bus.owner;
        for (int c = 0; c < 2000; c++) begin
            bus.cpu_breq_ = ($urandom_range(0, 9) < 5) ? 1'b0 : 1'b1;
            bus.dma_breq_ = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
            bus.dma_eop_  = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
            bus.cpu_rw_   = 1'($urandom_range(0, 1));
            bus.dma_rw_   = 1'($urandom_range(0, 1));
            bus.cpu_addr  = 10'($urandom);
            bus.dma_addr  = 10'($urandom);
            bus.cpu_wdata = 8'($urandom);
            bus.dma_wdata = 8'($urandom);
            step("rand");
            check_val("rand_mutex", {31'd0, bus.cpu_bgrt_ | bus.dma_bgrt_}, 32'd1);
            bad = (prev_own != 2'd0) && (bus.owner != 2'd0) && (bus.owner != prev_own);
            check_val("rand_turn", {31'd0, bad}, 32'd0);
            prev_own = bus.owner;
        end

        check_val("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
